// File: rtl/aes256_ks_pkg.sv
// Shared AES-256 key-schedule constants, FSM state type and byte/word helpers.
// Build option AES256_KS_INV_ORDER_EN lives in the top; nothing here depends on it.
package aes256_ks_pkg;

    localparam int NK     = 8;
    localparam int NR     = 14;
    localparam int NWORDS = 60;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } ks_state_t;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (0 maps to 0), then the FIPS-197 affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] rcon(input logic [2:0] n);
        logic [7:0] rc;
        rc = 8'h01 << (n - 3'd1);
        return {rc, 24'h000000};
    endfunction

    function automatic logic [31:0] rotword(input logic [31:0] wd);
        return {wd[23:0], wd[31:24]};
    endfunction

endpackage

// File: rtl/aes_subword.sv
// Four parallel S-box lookups on one 32-bit word; purely combinational.
// Single instance shared by both the RotWord and plain SubWord expansion steps.
module aes_subword
    import aes256_ks_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub
);

    always_comb begin
        sub = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};
    end

endmodule

// File: rtl/aes256_key_sched_ctrl.sv
// Iterative AES-256 key expander (one word per cycle, 52 cycles) with a 60-word store and
// a registered one-cycle round-key read port. Optional AES256_KS_INV_ORDER_EN adds `dec`.
module aes256_key_sched_ctrl
    import aes256_ks_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           key_valid,
    output logic           key_ready,
    input  logic [0:255]   key,
    output logic           busy,
    output logic           keys_valid,
    input  logic           rk_req,
    input  logic [3:0]     rk_idx,
    output logic           rk_valid,
    output logic [0:127]   rk_data,
    output logic           rk_err
`ifdef AES256_KS_INV_ORDER_EN
    ,
    input  logic           dec
`endif
);

    ks_state_t      state;
    logic [5:0]     cnt;
    logic [31:0]    w [0:NWORDS-1];
    logic [31:0]    wim1;
    logic [31:0]    wim8;
    logic [31:0]    sub_in;
    logic [31:0]    sub_out;
    logic [31:0]    nxt;
    logic [3:0]     eff_idx;
    logic [5:0]     base;
    logic           rd_ok;
    logic           load;
    logic [127:0]   rd_word;

    assign load = key_valid && key_ready && (state != EXPAND);

    always_comb begin
        wim1   = w[cnt - 6'd1];
        wim8   = w[cnt - 6'd8];
        sub_in = (cnt[2:0] == 3'd0) ? rotword(wim1) : wim1;
        case (cnt[2:0])
            3'd0:    nxt = sub_out ^ rcon(cnt[5:3]) ^ wim8;
            3'd4:    nxt = sub_out ^ wim8;
            default: nxt = wim1 ^ wim8;
        endcase
    end

    aes_subword u_subword (
        .word (sub_in),
        .sub  (sub_out)
    );

    // Range check uses the raw index; the inverse mapping only picks which words to read.
    always_comb begin
`ifdef AES256_KS_INV_ORDER_EN
        eff_idx = dec ? (4'(NR) - rk_idx) : rk_idx;
`else
        eff_idx = rk_idx;
`endif
        rd_ok   = keys_valid && (rk_idx <= 4'(NR));
        base    = (eff_idx > 4'(NR)) ? 6'd0 : {eff_idx, 2'b00};
        rd_word = {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (load) begin
                for (int j = 0; j < NK; j++) w[j] <= key[32*j +: 32];
            end else if (state == EXPAND) begin
                w[cnt] <= nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 6'd0;
            key_ready  <= 1'b0;
            busy       <= 1'b0;
            keys_valid <= 1'b0;
            rk_valid   <= 1'b0;
            rk_err     <= 1'b0;
            rk_data    <= '0;
        end else begin
            rk_valid <= rk_req;
            rk_err   <= rk_req && !rd_ok;
            rk_data  <= (rk_req && rd_ok) ? rd_word : 128'h0;
            case (state)
                IDLE, READY: begin
                    key_ready <= 1'b1;
                    if (load) begin
                        state      <= EXPAND;
                        cnt        <= 6'd8;
                        key_ready  <= 1'b0;
                        busy       <= 1'b1;
                        keys_valid <= 1'b0;
                    end
                end
                EXPAND: begin
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'(NWORDS - 1)) begin
                        state      <= READY;
                        busy       <= 1'b0;
                        keys_valid <= 1'b1;
                        key_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
// Self-checking bench: randomized keys and reads against a FIPS-197 style reference expansion.
module tb_aes256_key_sched_ctrl;

    logic           clk = 1'b0;
    logic           rst;
    logic           key_valid;
    logic           key_ready;
    logic [0:255]   key;
    logic           busy;
    logic           keys_valid;
    logic           rk_req;
    logic [3:0]     rk_idx;
    logic           rk_valid;
    logic [0:127]   rk_data;
    logic           rk_err;
`ifdef AES256_KS_INV_ORDER_EN
    logic           dec;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [0:59];

    localparam logic [0:255] KEY1 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [0:255] KEY2 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    aes256_key_sched_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key        (key),
        .busy       (busy),
        .keys_valid (keys_valid),
        .rk_req     (rk_req),
        .rk_idx     (rk_idx),
        .rk_valid   (rk_valid),
        .rk_data    (rk_data),
        .rk_err     (rk_err)
`ifdef AES256_KS_INV_ORDER_EN
        ,
        .dec        (dec)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = (x[7]) ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        logic [7:0] c   = 8'h63;
        logic [7:0] s;
        for (int y = 1; y < 256; y++)
            if (ref_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
        for (int b = 0; b < 8; b++)
            s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
        return s;
    endfunction

    function automatic logic [31:0] ref_subw(input logic [31:0] x);
        return {ref_sbox(x[31:24]), ref_sbox(x[23:16]), ref_sbox(x[15:8]), ref_sbox(x[7:0])};
    endfunction

    task automatic model_expand(input logic [0:255] k);
        logic [7:0]  rc = 8'h01;
        logic [31:0] t;
        for (int i = 0; i < 8; i++) mdl[i] = k[32*i +: 32];
        for (int i = 8; i < 60; i++) begin
            t = mdl[i-1];
            if (i % 8 == 0) begin
                t  = ref_subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = rc << 1;
            end else if (i % 8 == 4) begin
                t = ref_subw(t);
            end
            mdl[i] = mdl[i-8] ^ t;
        end
    endtask

    function automatic logic [127:0] model_rk(input int r);
        return {mdl[4*r], mdl[4*r+1], mdl[4*r+2], mdl[4*r+3]};
    endfunction

    function automatic logic [0:255] rand_key();
        logic [0:255] k;
        for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom();
        return k;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic load_key(input logic [0:255] k);
        int g = 0;
        @(negedge clk);
        key = k;
        key_valid = 1'b1;
        while (!key_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        total++;
        if (g >= 200) begin
            bad++;
            $display("FAIL load_accept: key_ready stayed low for %0d cycles, required high", g);
        end
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic wait_ready(output int cycles, output int busy_cycles);
        cycles = 0;
        busy_cycles = 0;
        while (!keys_valid && cycles < 200) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic rd(input logic [3:0] idx, output logic [127:0] d, output logic e, output logic v);
        @(negedge clk);
        rk_req = 1'b1;
        rk_idx = idx;
        @(negedge clk);
        d = rk_data;
        e = rk_err;
        v = rk_valid;
        rk_req = 1'b0;
    endtask

    task automatic check_all_rk(input string tag);
        logic [127:0] d;
        logic e, v;
        for (int r = 0; r < 15; r++) begin
            rd(4'(r), d, e, v);
            total++;
            if ({v, e, d} !== {1'b1, 1'b0, model_rk(r)}) begin
                bad++;
                $display("FAIL %s_rk%0d: got v=%0b e=%0b d=%h, required v=1 e=0 d=%h", tag, r, v, e, d, model_rk(r));
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({key_ready, busy, keys_valid, rk_valid, rk_err} !== 5'b0 || rk_data !== 128'h0) begin
            bad++;
            $display("FAIL reset_outputs: got kr=%0b busy=%0b kv=%0b v=%0b e=%0b d=%h, required all 0",
                     key_ready, busy, keys_valid, rk_valid, rk_err, rk_data);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (key_ready !== 1'b1 || keys_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got kr=%0b kv=%0b, required kr=1 kv=0", key_ready, keys_valid);
        end
    endtask

    task automatic test_std_key();
        int cyc, bcyc;
        logic [127:0] d;
        logic e, v;
        model_expand(KEY1);
        load_key(KEY1);
        total++;
        if (key_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL expand_flags: got kr=%0b busy=%0b, required kr=0 busy=1", key_ready, busy);
        end
        wait_ready(cyc, bcyc);
        total++;
        if (cyc != 52 || bcyc != 52 || busy !== 1'b0) begin
            bad++;
            $display("FAIL expand_latency: got kv after %0d, busy %0d cycles, busy_end=%0b, required 52/52/0", cyc, bcyc, busy);
        end
        rd(4'd2, d, e, v);
        total++;
        if (d[127:64] !== 64'h9ba354118e6925af) begin
            bad++;
            $display("FAIL std_w8_w9: got %h, required 9ba354118e6925af", d[127:64]);
        end
        rd(4'd1, d, e, v);
        total++;
        if (d !== 128'h1f352c073b6108d72d9810a30914dff4 || e !== 1'b0) begin
            bad++;
            $display("FAIL std_rk1: got %h e=%0b, required 1f352c073b6108d72d9810a30914dff4 e=0", d, e);
        end
        rd(4'd14, d, e, v);
        total++;
        if (d !== 128'hfe4890d1e6188d0b046df344706c631e) begin
            bad++;
            $display("FAIL std_rk14: got %h, required fe4890d1e6188d0b046df344706c631e", d);
        end
        check_all_rk("std");
    endtask

    task automatic test_second_key();
        int cyc, bcyc;
        logic [127:0] d;
        logic e, v;
        model_expand(KEY2);
        load_key(KEY2);
        rd(4'd3, d, e, v);
        total++;
        if ({v, e, d} !== {1'b1, 1'b1, 128'h0}) begin
            bad++;
            $display("FAIL early_read: got v=%0b e=%0b d=%h, required v=1 e=1 d=0", v, e, d);
        end
        wait_ready(cyc, bcyc);
        rd(4'd0, d, e, v);
        total++;
        if (d !== 128'h000102030405060708090a0b0c0d0e0f) begin
            bad++;
            $display("FAIL key2_rk0: got %h, required 000102030405060708090a0b0c0d0e0f", d);
        end
        rd(4'd14, d, e, v);
        total++;
        if (d !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin
            bad++;
            $display("FAIL key2_rk14: got %h, required 24fc79ccbf0979e9371ac23c6d68de36", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] prev = 4'd0;
        logic [127:0] exp_d;
        logic exp_e;
        for (int n = 0; n <= 24; n++) begin
            @(negedge clk);
            if (n > 0) begin
                exp_e = (prev > 4'd14);
                exp_d = exp_e ? 128'h0 : model_rk(int'(prev));
                total++;
                if ({rk_valid, rk_err, rk_data} !== {1'b1, exp_e, exp_d}) begin
                    bad++;
                    $display("FAIL b2b_idx%0d: got v=%0b e=%0b d=%h, required v=1 e=%0b d=%h",
                             prev, rk_valid, rk_err, rk_data, exp_e, exp_d);
                end
            end
            prev = (n == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            rk_req = (n < 24);
            rk_idx = prev;
        end
        @(negedge clk);
        total++;
        if (rk_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle: got rk_valid=%0b, required 0", rk_valid);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, bcyc;
        logic [127:0] d;
        logic e, v;
        load_key(rand_key());
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (keys_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midrst_state: got kv=%0b busy=%0b, required 0/0", keys_valid, busy);
        end
        @(negedge clk);
        total++;
        if (key_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_ready: got kr=%0b, required 1", key_ready);
        end
        rd(4'd5, d, e, v);
        total++;
        if ({v, e, d} !== {1'b1, 1'b1, 128'h0}) begin
            bad++;
            $display("FAIL midrst_read: got v=%0b e=%0b d=%h, required v=1 e=1 d=0", v, e, d);
        end
        model_expand(KEY1);
        load_key(KEY1);
        wait_ready(cyc, bcyc);
        rd(4'd14, d, e, v);
        total++;
        if (d !== 128'hfe4890d1e6188d0b046df344706c631e) begin
            bad++;
            $display("FAIL reload_rk14: got %h, required fe4890d1e6188d0b046df344706c631e", d);
        end
    endtask

    task automatic test_simul_load_read();
        int cyc, bcyc;
        logic [0:255] nk;
        logic [127:0] old14;
        nk = rand_key();
        old14 = model_rk(14);
        @(negedge clk);
        key = nk;
        key_valid = 1'b1;
        rk_req = 1'b1;
        rk_idx = 4'd14;
        @(negedge clk);
        total++;
        if ({rk_valid, rk_err, rk_data} !== {1'b1, 1'b0, old14} || keys_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL simul_load_read: got v=%0b e=%0b d=%h kv=%0b busy=%0b, required v=1 e=0 d=%h kv=0 busy=1",
                     rk_valid, rk_err, rk_data, keys_valid, busy, old14);
        end
        key_valid = 1'b0;
        rk_req = 1'b0;
        wait_ready(cyc, bcyc);
        total++;
        if (cyc != 52) begin
            bad++;
            $display("FAIL simul_latency: got %0d, required 52", cyc);
        end
        model_expand(nk);
        check_all_rk("simul");
    endtask

    task automatic test_random_keys();
        int cyc, bcyc;
        logic [0:255] k;
        for (int n = 0; n < 2; n++) begin
            k = rand_key();
            model_expand(k);
            load_key(k);
            wait_ready(cyc, bcyc);
            check_all_rk("rand");
        end
    endtask

`ifdef AES256_KS_INV_ORDER_EN
    task automatic test_inv_order();
        int cyc, bcyc;
        logic [127:0] d;
        logic e, v;
        model_expand(KEY1);
        load_key(KEY1);
        wait_ready(cyc, bcyc);
        dec = 1'b1;
        rd(4'd0, d, e, v);
        total++;
        if (d !== 128'hfe4890d1e6188d0b046df344706c631e || e !== 1'b0) begin
            bad++;
            $display("FAIL inv_rk0: got %h e=%0b, required fe4890d1e6188d0b046df344706c631e e=0", d, e);
        end
        rd(4'd15, d, e, v);
        total++;
        if ({e, d} !== {1'b1, 128'h0}) begin
            bad++;
            $display("FAIL inv_idx15: got e=%0b d=%h, required e=1 d=0", e, d);
        end
        dec = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1;
        key_valid = 1'b0;
        key = '0;
        rk_req = 1'b0;
        rk_idx = 4'd0;
`ifdef AES256_KS_INV_ORDER_EN
        dec = 1'b0;
`endif
        test_reset();
        test_std_key();
        test_second_key();
        test_back_to_back();
        test_reset_mid();
        test_simul_load_read();
        test_random_keys();
`ifdef AES256_KS_INV_ORDER_EN
        test_inv_order();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
